spi_resp_regfile: RTL and testbench

Synthesizable 3-wire SPI responder that models the gyro-side register bank addressed by the tester's SPI master (chip-select, clock and a single bidirectional data line). It oversamples the SPI signals in the `ACLK` domain, decodes 24-bit write/read frames, and holds a 16 x 16-bit register file. Read data is returned on the shared data line. It is instantiated in the PL next to the SPI master for loopback bring-up, and in benches as the responder end of the link.

---
 rtl/spi_resp_regfile.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_spi_resp_regfile.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_resp_regfile.sv
// spi_resp_regfile: 3-wire SPI responder with a 16 x 16-bit register bank.
// All SPI inputs are oversampled in the ACLK domain. A frame is 24 bits:
// R/W, 7-bit address, 16-bit data.
// Optional feature macro: SPI_RESP_WRCNT_EN. When it is defined, address
// 0x0E becomes a read-only counter of committed writes.
module spi_resp_regfile #(
  parameter logic [15:0] ID_VALUE    = 16'hA5C3,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        spi_sck,
  input  logic        spi_csn,
  input  logic        spi_d_i,
  output logic        spi_d_o,
  output logic        spi_d_oe,
  output logic        wr_strobe,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Writes land only in the 16-entry bank, never on the ID register
  // (and never on the write counter when that is enabled).
  function automatic logic addr_writable(input logic [6:0] a);
    logic ok;
    ok = 1'b0;
    if (a[6:4] != 3'b000) begin
      ok = 1'b0;
    end else if (a[3:0] == 4'hF) begin
      ok = 1'b0;
`ifdef SPI_RESP_WRCNT_EN
    end else if (a[3:0] == 4'hE) begin
      ok = 1'b0;
`endif
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  // Synchronizers and previous-value flops.
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   csn_prev_q, csn_prev_d;

  // Frame state.
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [23:0] rx_q, rx_d;
  logic [15:0] rd_shift_q, rd_shift_d;
  logic        rd_active_q, rd_active_d;
  logic        commit_pend_q, commit_pend_d;
  logic        err_pend_q, err_pend_d;
  logic [3:0]  pend_addr_q, pend_addr_d;
  logic [15:0] pend_data_q, pend_data_d;

  // Registered outputs and register bank.
  logic        spi_d_o_q, spi_d_o_d;
  logic        spi_d_oe_q, spi_d_oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] rf_q [16];
  logic [15:0] rf_d [16];

  // Edge detection on the synchronized inputs.
  logic        sck_s, csn_s, din_s;
  logic        cs_rise_s, cs_fall_s, sck_rise_s, sck_fall_s;
  logic [23:0] rx_next_s;
  logic [5:0]  cnt_inc_s;
  logic [15:0] rd_val_s;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign csn_s      = csn_sync_q[SYNC_STAGES-1];
  assign din_s      = din_sync_q[SYNC_STAGES-1];
  assign cs_rise_s  = csn_s & ~csn_prev_q;
  assign cs_fall_s  = ~csn_s & csn_prev_q;
  // A CS rise in the same cycle masks any SCK edge.
  assign sck_rise_s = sck_s & ~sck_prev_q & ~cs_rise_s;
  assign sck_fall_s = ~sck_s & sck_prev_q & ~cs_rise_s;
  assign rx_next_s  = {rx_q[22:0], din_s};
  assign cnt_inc_s  = (cnt_q == 6'd63) ? cnt_q : (cnt_q + 6'd1);
  assign rd_val_s   = (rx_next_s[6:4] == 3'b000) ? rf_q[rx_next_s[3:0]] : 16'h0000;

  // Synchronizer shift and previous-value capture.
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    csn_sync_d = {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
    din_sync_d = {din_sync_q[SYNC_STAGES-2:0], spi_d_i};
    sck_prev_d = sck_s;
    csn_prev_d = csn_s;
  end

  // Frame FSM: edge counting, command decode, shifters and frame evaluation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_d          = rx_q;
    rd_shift_d    = rd_shift_q;
    rd_active_d   = rd_active_q;
    commit_pend_d = 1'b0;
    err_pend_d    = 1'b0;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    if (cs_rise_s) begin
      if (state_q != ST_IDLE) begin
        if (cnt_q != 6'd24) begin
          err_pend_d = 1'b1;
        end else if (!rx_q[23] && addr_writable(rx_q[22:16])) begin
          commit_pend_d = 1'b1;
          pend_addr_d   = rx_q[19:16];
          pend_data_d   = rx_q[15:0];
        end else begin
          commit_pend_d = 1'b0;
        end
      end else begin
        err_pend_d = 1'b0;
      end
      state_d     = ST_IDLE;
      rd_active_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_d     = ST_CMD;
            cnt_d       = 6'd0;
            rd_active_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (sck_rise_s) begin
            rx_d  = rx_next_s;
            cnt_d = cnt_inc_s;
            if (cnt_q == 6'd7) begin
              if (rx_next_s[7]) begin
                state_d    = ST_RDATA;
                rd_shift_d = rd_val_s;
              end else begin
                state_d = ST_WDATA;
              end
            end else begin
              state_d = ST_CMD;
            end
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_WDATA: begin
          if (sck_rise_s) begin
            rx_d  = rx_next_s;
            cnt_d = cnt_inc_s;
            if (cnt_q == 6'd23) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_WDATA;
            end
          end else begin
            state_d = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (sck_rise_s) begin
            rx_d  = rx_next_s;
            cnt_d = cnt_inc_s;
            if (cnt_q == 6'd23) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RDATA;
            end
          end else if (sck_fall_s) begin
            if (!rd_active_q) begin
              rd_active_d = 1'b1;
            end else begin
              rd_shift_d = {rd_shift_q[14:0], 1'b0};
            end
          end else begin
            state_d = ST_RDATA;
          end
        end
        ST_DONE: begin
          if (sck_rise_s) begin
            cnt_d = cnt_inc_s;
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          rd_active_d = 1'b0;
        end
      endcase
    end
  end

  // Output stage and register-bank update, one cycle behind the FSM.
  always_comb begin
    spi_d_oe_d  = rd_active_q;
    spi_d_o_d   = rd_active_q & rd_shift_q[15];
    wr_strobe_d = commit_pend_q;
    frame_err_d = err_pend_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rf_d        = rf_q;
    if (commit_pend_q) begin
      wr_addr_d             = pend_addr_q;
      wr_data_d             = pend_data_q;
      rf_d[pend_addr_q]     = pend_data_q;
`ifdef SPI_RESP_WRCNT_EN
      rf_d[14]              = rf_q[14] + 16'd1;
`endif
    end else begin
      wr_addr_d = wr_addr_q;
    end
  end

  // State register for every flop in the block.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sck_sync_q    <= '0;
      csn_sync_q    <= '0;
      din_sync_q    <= '0;
      sck_prev_q    <= 1'b0;
      csn_prev_q    <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= 6'd0;
      rx_q          <= 24'h000000;
      rd_shift_q    <= 16'h0000;
      rd_active_q   <= 1'b0;
      commit_pend_q <= 1'b0;
      err_pend_q    <= 1'b0;
      pend_addr_q   <= 4'h0;
      pend_data_q   <= 16'h0000;
      spi_d_o_q     <= 1'b0;
      spi_d_oe_q    <= 1'b0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= 4'h0;
      wr_data_q     <= 16'h0000;
      frame_err_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= (i == 15) ? ID_VALUE : 16'h0000;
      end
    end else begin
      sck_sync_q    <= sck_sync_d;
      csn_sync_q    <= csn_sync_d;
      din_sync_q    <= din_sync_d;
      sck_prev_q    <= sck_prev_d;
      csn_prev_q    <= csn_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_q          <= rx_d;
      rd_shift_q    <= rd_shift_d;
      rd_active_q   <= rd_active_d;
      commit_pend_q <= commit_pend_d;
      err_pend_q    <= err_pend_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      spi_d_o_q     <= spi_d_o_d;
      spi_d_oe_q    <= spi_d_oe_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_err_q   <= frame_err_d;
      rf_q          <= rf_d;
    end
  end

  assign spi_d_o   = spi_d_o_q;
  assign spi_d_oe  = spi_d_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_resp_regfile.sv
// tb_spi_resp_regfile: drives SPI frames into spi_resp_regfile and compares
// strobes, errors and read data against an array model of the register bank.
module tb_spi_resp_regfile;

  localparam logic [15:0] ID = 16'hA5C3;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        spi_sck, spi_csn, spi_d_i;
  logic        spi_d_o, spi_d_oe, wr_strobe, frame_err;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  int total = 0;
  int bad   = 0;

  // Monitor counters (written only by the monitor process).
  int          stb_cnt  = 0;
  int          err_cnt  = 0;
  int          both_cnt = 0;
  logic [3:0]  last_addr = 4'h0;
  logic [15:0] last_data = 16'h0000;

  // Reference register bank.
  logic [15:0] rf_m [16];

  spi_resp_regfile #(.ID_VALUE(ID), .SYNC_STAGES(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .spi_sck(spi_sck), .spi_csn(spi_csn),
    .spi_d_i(spi_d_i), .spi_d_o(spi_d_o), .spi_d_oe(spi_d_oe),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err)
  );

  always #5 ACLK = ~ACLK;

  // Count strobe and error cycles away from the active edge.
  always @(negedge ACLK) begin
    if (wr_strobe === 1'b1) begin
      stb_cnt   <= stb_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (wr_strobe === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_writable(input logic [6:0] a);
`ifdef SPI_RESP_WRCNT_EN
    return (a < 7'd16) && (a != 7'h0F) && (a != 7'h0E);
`else
    return (a < 7'd16) && (a != 7'h0F);
`endif
  endfunction

  function automatic logic [15:0] model_read(input logic [6:0] a);
    return (a < 7'd16) ? rf_m[a[3:0]] : 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rf_m[i] = (i == 15) ? ID : 16'h0000;
  endtask

  // One frame of nbits SCK periods; optional ARESET pulse during bit rst_at.
  task automatic do_frame(input logic [23:0] word, input int nbits, input int rst_at,
                          output logic [15:0] rd, output logic oe_ok);
    logic rdf;
    rdf   = word[23];
    rd    = 16'h0000;
    oe_ok = 1'b1;
    @(negedge ACLK);
    spi_csn = 1'b0;
    repeat (6) @(negedge ACLK);
    for (int i = 0; i < nbits; i++) begin
      spi_d_i = (i < 24) ? word[23-i] : 1'($urandom_range(0, 1));
      repeat (5) @(negedge ACLK);
      if (i < 24 && rst_at < 0) begin
        if (spi_d_oe !== (rdf && i >= 8)) oe_ok = 1'b0;
        if (i >= 8) rd[23-i] = spi_d_o;
      end
      spi_sck = 1'b1;
      if (i == rst_at) begin
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        chk_val("oe_after_rst", {31'd0, spi_d_oe}, 32'd0);
      end
      repeat (5) @(negedge ACLK);
      spi_sck = 1'b0;
      @(negedge ACLK);
    end
    repeat (5) @(negedge ACLK);
    spi_csn = 1'b1;
    repeat (12) @(negedge ACLK);
  endtask

  // Run one frame and compare it with what the model predicts.
  task automatic run_frame(input string tag, input logic rw, input logic [6:0] a,
                           input logic [15:0] d, input int nbits, input int rst_at);
    logic [15:0] rd, exp_rd;
    logic        oe_ok, exp_commit, exp_err;
    int          s0, e0;
    s0         = stb_cnt;
    e0         = err_cnt;
    exp_rd     = model_read(a);
    exp_commit = (rst_at < 0) && !rw && (nbits == 24) && model_writable(a);
    exp_err    = (rst_at < 0) && (nbits != 24);
    do_frame({rw, a, d}, nbits, rst_at, rd, oe_ok);
    chk_val({tag, "_stb"}, 32'(stb_cnt - s0), {31'd0, exp_commit});
    chk_val({tag, "_err"}, 32'(err_cnt - e0), {31'd0, exp_err});
    chk_val({tag, "_oe_idle"}, {31'd0, spi_d_oe}, 32'd0);
    if (exp_commit) begin
      chk_val({tag, "_waddr"}, {28'd0, last_addr}, {28'd0, a[3:0]});
      chk_val({tag, "_wdata"}, {16'd0, last_data}, {16'd0, d});
      rf_m[a[3:0]] = d;
`ifdef SPI_RESP_WRCNT_EN
      rf_m[14] = rf_m[14] + 16'd1;
`endif
    end
    if (rst_at >= 0) begin
      model_reset();
    end else if (rw && nbits >= 24) begin
      chk_val({tag, "_oe_seq"}, {31'd0, oe_ok}, 32'd1);
      chk_val({tag, "_rdata"}, {16'd0, rd}, {16'd0, exp_rd});
    end
  endtask

  initial begin
    ARESET  = 1'b1;
    spi_sck = 1'b0;
    spi_csn = 1'b1;
    spi_d_i = 1'b0;
    model_reset();
    repeat (5) @(negedge ACLK);
    chk_val("rst_outputs", {8'd0, spi_d_o, spi_d_oe, wr_strobe, frame_err, wr_addr, wr_data},
            32'd0);
    ARESET = 1'b0;
    repeat (6) @(negedge ACLK);

    run_frame("rd_id",     1'b1, 7'h0F, 16'h0000, 24, -1);
    run_frame("wr3",       1'b0, 7'h03, 16'h1234, 24, -1);
    run_frame("rd3",       1'b1, 7'h03, 16'h0000, 24, -1);
    run_frame("wr20",      1'b0, 7'h20, 16'hFFFF, 24, -1);
    run_frame("rd20",      1'b1, 7'h20, 16'h0000, 24, -1);
    run_frame("wr_id",     1'b0, 7'h0F, 16'h5555, 24, -1);
    run_frame("rd_id2",    1'b1, 7'h0F, 16'h0000, 24, -1);
    run_frame("short5",    1'b0, 7'h05, 16'hCAFE, 20, -1);
    run_frame("long5",     1'b0, 7'h05, 16'hCAFE, 26, -1);
    run_frame("rd5",       1'b1, 7'h05, 16'h0000, 24, -1);
    run_frame("short_rd",  1'b1, 7'h03, 16'h0000, 12, -1);
    run_frame("rst_wr7",   1'b0, 7'h07, 16'hBEEF, 24, 12);
    run_frame("rd7",       1'b1, 7'h07, 16'h0000, 24, -1);
    run_frame("rd3_rst",   1'b1, 7'h03, 16'h0000, 24, -1);
    run_frame("wr1",       1'b0, 7'h01, 16'h0101, 24, -1);
    run_frame("wr2",       1'b0, 7'h02, 16'h0202, 24, -1);
    run_frame("wr4",       1'b0, 7'h04, 16'h0404, 24, -1);
    run_frame("rd_e",      1'b1, 7'h0E, 16'h0000, 24, -1);
    run_frame("wr_e",      1'b0, 7'h0E, 16'h00AA, 24, -1);
    run_frame("rd_e2",     1'b1, 7'h0E, 16'h0000, 24, -1);

    for (int k = 0; k < 30; k++) begin
      logic        rw;
      logic [6:0]  a;
      logic [15:0] d;
      int          nb;
      rw = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) != 0) ? {3'b000, 4'($urandom_range(0, 15))}
                                       : 7'($urandom_range(0, 127));
      d  = 16'($urandom);
      nb = ($urandom_range(0, 9) < 7) ? 24 : $urandom_range(16, 28);
      run_frame("rand", rw, a, d, nb, -1);
    end

    chk_val("strobe_err_excl", 32'(both_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
